instr_fetch: RTL and testbench

Instruction fetch stage of the 16-bit core. It is the producer side of the decode stage's `instr` input. It owns the program counter and issues reads to a synchronous instruction memory with one-cycle read latency. Returned words go into a two-entry prefetch buffer that presents `instr`/`instr_valid` to ID. It also applies jump redirects (`jenable`, `jop_lsb`, `addr`) coming back from ID.

---
 rtl/instr_fetch_if.sv | 28 ++
 rtl/instr_fetch.sv | 85 ++++++++
 tb/tb_instr_fetch.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read port plus the ID-facing
// instruction/redirect signals. master = fetch stage, slave = memory/ID side.
interface instr_fetch_if #(
  parameter int ARQ = 16,
  parameter int AW  = 14
);
  logic           stall;
  logic           jenable;
  logic           jop_lsb;
  logic           cmp_flag;
  logic [AW-1:0]  addr;
  logic           imem_rd;
  logic [AW-1:0]  imem_addr;
  logic [ARQ-1:0] imem_data;
  logic [ARQ-1:0] instr;
  logic           instr_valid;
  logic [AW-1:0]  pc_out;

  modport master (
    input  stall, jenable, jop_lsb, cmp_flag, addr, imem_data,
    output imem_rd, imem_addr, instr, instr_valid, pc_out
  );

  modport slave (
    output stall, jenable, jop_lsb, cmp_flag, addr, imem_data,
    input  imem_rd, imem_addr, instr, instr_valid, pc_out
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, one-outstanding-read issue to a 1-cycle synchronous
// imem, a 2-entry prefetch buffer feeding ID, and J/JEQ redirect handling.
module instr_fetch #(
  parameter int ARQ = 16,
  parameter int AW  = 14
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);

  logic [AW-1:0]  fetch_pc;
  logic [AW-1:0]  buf_pc   [2];
  logic [ARQ-1:0] buf_word [2];
  logic [1:0]     count;
  logic           inflight;

  logic           take;
  logic           pop;
  logic           push;
  logic           rd;
  logic [2:0]     occ;
  logic [AW-1:0]  ret_pc;

  always_comb begin
    take   = bus.jenable & (~bus.jop_lsb | bus.cmp_flag);
    pop    = (count != 2'd0) & ~bus.stall;
    push   = inflight & ~take;
    occ    = {1'b0, count} + {2'b00, inflight};
    // rst gate keeps the strobe low while reset is held
    rd     = rst & ~take & (occ < (3'd2 + {2'b00, pop}));
    // inflight implies the previous edge issued, so the returning word's pc is fetch_pc-1
    ret_pc = fetch_pc - AW'(1);
  end

  assign bus.imem_rd     = rd;
  assign bus.imem_addr   = fetch_pc;
  assign bus.instr_valid = (count != 2'd0);
  assign bus.instr       = (count != 2'd0) ? buf_word[0] : '0;
  assign bus.pc_out      = (count != 2'd0) ? buf_pc[0]   : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= '0;
      count       <= '0;
      inflight    <= 1'b0;
      buf_pc[0]   <= '0;
      buf_pc[1]   <= '0;
      buf_word[0] <= '0;
      buf_word[1] <= '0;
    end else if (take) begin
      fetch_pc <= bus.addr;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd;
      if (rd) fetch_pc <= fetch_pc + AW'(1);
      case ({push, pop})
        2'b10: begin
          buf_pc[count[0]]   <= ret_pc;
          buf_word[count[0]] <= bus.imem_data;
          count              <= count + 2'd1;
        end
        2'b01: begin
          buf_pc[0]   <= buf_pc[1];
          buf_word[0] <= buf_word[1];
          count       <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            buf_pc[0]   <= buf_pc[1];
            buf_word[0] <= buf_word[1];
            buf_pc[1]   <= ret_pc;
            buf_word[1] <= bus.imem_data;
          end else begin
            buf_pc[0]   <= ret_pc;
            buf_word[0] <= bus.imem_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: behavioural imem (mem[i]=0x1000+i) and a
// scoreboard of expected presented pcs, popped whenever ID consumes a word.
module tb_instr_fetch;
  localparam int ARQ = 16;
  localparam int AW  = 14;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [AW-1:0] sb_q[$];

  instr_fetch_if #(.ARQ(ARQ), .AW(AW)) bus ();
  instr_fetch #(.ARQ(ARQ), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [ARQ-1:0] mem_word(input logic [AW-1:0] a);
    return 16'h1000 + ARQ'(a);
  endfunction

  always @(posedge clk) if (bus.imem_rd === 1'b1) bus.imem_data <= mem_word(bus.imem_addr);

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    rst = 1'b0;
    bus.stall = 1'b0; bus.jenable = 1'b0; bus.jop_lsb = 1'b0; bus.cmp_flag = 1'b0; bus.addr = '0;
    next_cycle();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.stall = 1'b0; bus.jenable = 1'b0; bus.jop_lsb = 1'b0; bus.cmp_flag = 1'b0; bus.addr = '0;
    @(negedge clk);
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.instr_valid); end
    checks++; if (bus.imem_rd !== 1'b0) begin errors++; $display("FAIL reset_rd got=%b exp=0", bus.imem_rd); end
    checks++; if (bus.imem_addr !== '0) begin errors++; $display("FAIL reset_addr got=%h exp=0", bus.imem_addr); end
    checks++; if (bus.instr !== '0) begin errors++; $display("FAIL reset_instr got=%h exp=0", bus.instr); end
    checks++; if (bus.pc_out !== '0) begin errors++; $display("FAIL reset_pc got=%h exp=0", bus.pc_out); end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.imem_rd !== 1'b1 || bus.imem_addr !== '0) begin
      errors++; $display("FAIL reset_first_issue got rd=%b addr=%h exp rd=1 addr=0", bus.imem_rd, bus.imem_addr);
    end
    next_cycle();
  endtask

  task automatic test_stream();
    logic [AW-1:0] exp_pc;
    logic ev;
    restart();
    sb_q = {14'd0, 14'd1, 14'd2};
    for (int c = 0; c < 5; c++) begin
      ev = (c >= 2);
      @(negedge clk);
      checks++; if (bus.instr_valid !== ev) begin errors++; $display("FAIL stream_valid c=%0d got=%b exp=%b", c, bus.instr_valid, ev); end
      if (c < 2) begin
        checks++; if (bus.instr !== '0 || bus.pc_out !== '0) begin
          errors++; $display("FAIL stream_idle_zero c=%0d got instr=%h pc=%h exp 0/0", c, bus.instr, bus.pc_out);
        end
      end
      if (bus.instr_valid === 1'b1 && bus.stall === 1'b0) begin
        checks++;
        if (sb_q.size() == 0) begin errors++; $display("FAIL stream_sb c=%0d got pc=%h exp=<none>", c, bus.pc_out); end
        else begin
          exp_pc = sb_q.pop_front();
          if (bus.pc_out !== exp_pc || bus.instr !== mem_word(exp_pc)) begin
            errors++; $display("FAIL stream_sb c=%0d got pc=%h instr=%h exp pc=%h instr=%h", c, bus.pc_out, bus.instr, exp_pc, mem_word(exp_pc));
          end
        end
      end
      next_cycle();
    end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL stream_left got=%0d exp=0", sb_q.size()); end
  endtask

  task automatic test_stall();
    logic [AW-1:0] exp_pc;
    restart();
    sb_q = {14'd0, 14'd1, 14'd2, 14'd3, 14'd4, 14'd5};
    for (int c = 0; c < 13; c++) begin
      bus.stall = (c >= 5 && c <= 9);
      @(negedge clk);
      if (c >= 2) begin
        checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid c=%0d got=%b exp=1", c, bus.instr_valid); end
      end
      if (c >= 5 && c <= 9) begin
        checks++; if (bus.instr !== 16'h1003 || bus.pc_out !== 14'd3) begin
          errors++; $display("FAIL stall_hold c=%0d got instr=%h pc=%h exp 1003/3", c, bus.instr, bus.pc_out);
        end
      end
      if (c >= 7 && c <= 9) begin
        checks++; if (bus.imem_rd !== 1'b0) begin errors++; $display("FAIL stall_rd_off c=%0d got=%b exp=0", c, bus.imem_rd); end
      end
      if (bus.instr_valid === 1'b1 && bus.stall === 1'b0) begin
        checks++;
        if (sb_q.size() == 0) begin errors++; $display("FAIL stall_sb c=%0d got pc=%h exp=<none>", c, bus.pc_out); end
        else begin
          exp_pc = sb_q.pop_front();
          if (bus.pc_out !== exp_pc || bus.instr !== mem_word(exp_pc)) begin
            errors++; $display("FAIL stall_sb c=%0d got pc=%h instr=%h exp pc=%h instr=%h", c, bus.pc_out, bus.instr, exp_pc, mem_word(exp_pc));
          end
        end
      end
      next_cycle();
    end
    bus.stall = 1'b0;
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL stall_left got=%0d exp=0", sb_q.size()); end
  endtask

  task automatic test_jump();
    logic [AW-1:0] exp_pc;
    logic ev;
    restart();
    sb_q = {14'd0, 14'd1, 14'd5, 14'd6};
    for (int c = 0; c < 8; c++) begin
      bus.jenable = (c == 3); bus.jop_lsb = 1'b0; bus.addr = 14'd5;
      ev = (c == 2 || c == 3 || c >= 6);
      @(negedge clk);
      checks++; if (bus.instr_valid !== ev) begin errors++; $display("FAIL jump_valid c=%0d got=%b exp=%b", c, bus.instr_valid, ev); end
      if (c == 3) begin
        checks++; if (bus.imem_rd !== 1'b0) begin errors++; $display("FAIL jump_no_issue got rd=%b exp=0", bus.imem_rd); end
      end
      if (c == 4) begin
        checks++; if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 14'd5) begin
          errors++; $display("FAIL jump_target_issue got rd=%b addr=%h exp rd=1 addr=5", bus.imem_rd, bus.imem_addr);
        end
      end
      if (bus.instr_valid === 1'b1 && bus.stall === 1'b0) begin
        checks++;
        if (sb_q.size() == 0) begin errors++; $display("FAIL jump_sb c=%0d got pc=%h exp=<none>", c, bus.pc_out); end
        else begin
          exp_pc = sb_q.pop_front();
          if (bus.pc_out !== exp_pc || bus.instr !== mem_word(exp_pc)) begin
            errors++; $display("FAIL jump_sb c=%0d got pc=%h instr=%h exp pc=%h instr=%h", c, bus.pc_out, bus.instr, exp_pc, mem_word(exp_pc));
          end
        end
      end
      next_cycle();
    end
    bus.jenable = 1'b0;
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL jump_left got=%0d exp=0", sb_q.size()); end
  endtask

  task automatic test_jeq();
    logic [AW-1:0] exp_pc;
    logic ev;
    restart();
    sb_q = {14'd0, 14'd1, 14'd2, 14'd3, 14'd4, 14'd5};
    for (int c = 0; c < 10; c++) begin
      bus.jenable = (c == 3 || c == 5); bus.jop_lsb = 1'b1; bus.cmp_flag = (c == 5); bus.addr = 14'd4;
      ev = (c >= 2 && c <= 5) || (c >= 8);
      @(negedge clk);
      checks++; if (bus.instr_valid !== ev) begin errors++; $display("FAIL jeq_valid c=%0d got=%b exp=%b", c, bus.instr_valid, ev); end
      if (c == 3) begin
        checks++; if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 14'd3) begin
          errors++; $display("FAIL jeq_not_taken_issue got rd=%b addr=%h exp rd=1 addr=3", bus.imem_rd, bus.imem_addr);
        end
      end
      if (bus.instr_valid === 1'b1 && bus.stall === 1'b0) begin
        checks++;
        if (sb_q.size() == 0) begin errors++; $display("FAIL jeq_sb c=%0d got pc=%h exp=<none>", c, bus.pc_out); end
        else begin
          exp_pc = sb_q.pop_front();
          if (bus.pc_out !== exp_pc || bus.instr !== mem_word(exp_pc)) begin
            errors++; $display("FAIL jeq_sb c=%0d got pc=%h instr=%h exp pc=%h instr=%h", c, bus.pc_out, bus.instr, exp_pc, mem_word(exp_pc));
          end
        end
      end
      next_cycle();
    end
    bus.jenable = 1'b0; bus.jop_lsb = 1'b0; bus.cmp_flag = 1'b0;
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL jeq_left got=%0d exp=0", sb_q.size()); end
  endtask

  task automatic test_jump_stall_wrap();
    logic [AW-1:0] exp_pc;
    logic ev;
    restart();
    sb_q = {14'd0, 14'h3FFF, 14'h0000};
    for (int c = 0; c < 8; c++) begin
      bus.stall = (c == 3); bus.jenable = (c == 3); bus.jop_lsb = 1'b0; bus.addr = 14'h3FFF;
      ev = (c == 2 || c == 3 || c >= 6);
      @(negedge clk);
      checks++; if (bus.instr_valid !== ev) begin errors++; $display("FAIL wrap_valid c=%0d got=%b exp=%b", c, bus.instr_valid, ev); end
      if (c == 3) begin
        checks++; if (bus.pc_out !== 14'd1) begin errors++; $display("FAIL wrap_stalled_pc got=%h exp=1", bus.pc_out); end
      end
      if (c == 4) begin
        checks++; if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 14'h3FFF) begin
          errors++; $display("FAIL wrap_target_issue got rd=%b addr=%h exp rd=1 addr=3fff", bus.imem_rd, bus.imem_addr);
        end
      end
      if (bus.instr_valid === 1'b1 && bus.stall === 1'b0) begin
        checks++;
        if (sb_q.size() == 0) begin errors++; $display("FAIL wrap_sb c=%0d got pc=%h exp=<none>", c, bus.pc_out); end
        else begin
          exp_pc = sb_q.pop_front();
          if (bus.pc_out !== exp_pc || bus.instr !== mem_word(exp_pc)) begin
            errors++; $display("FAIL wrap_sb c=%0d got pc=%h instr=%h exp pc=%h instr=%h", c, bus.pc_out, bus.instr, exp_pc, mem_word(exp_pc));
          end
        end
      end
      next_cycle();
    end
    bus.stall = 1'b0; bus.jenable = 1'b0;
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL wrap_left got=%0d exp=0", sb_q.size()); end
  endtask

  task automatic test_async_reset();
    logic [AW-1:0] exp_pc;
    logic ev;
    restart();
    sb_q = {14'd0};
    for (int c = 0; c < 6; c++) begin
      bus.stall = (c >= 3);
      @(negedge clk);
      if (c >= 4) begin
        checks++; if (bus.imem_rd !== 1'b0 || bus.pc_out !== 14'd1) begin
          errors++; $display("FAIL arst_full c=%0d got rd=%b pc=%h exp rd=0 pc=1", c, bus.imem_rd, bus.pc_out);
        end
      end
      if (bus.instr_valid === 1'b1 && bus.stall === 1'b0) begin
        checks++;
        if (sb_q.size() == 0) begin errors++; $display("FAIL arst_sb c=%0d got pc=%h exp=<none>", c, bus.pc_out); end
        else begin
          exp_pc = sb_q.pop_front();
          if (bus.pc_out !== exp_pc || bus.instr !== mem_word(exp_pc)) begin
            errors++; $display("FAIL arst_sb c=%0d got pc=%h instr=%h exp pc=%h instr=%h", c, bus.pc_out, bus.instr, exp_pc, mem_word(exp_pc));
          end
        end
      end
      if (c < 5) next_cycle();
    end
    #1 rst = 1'b0;
    #1;
    checks++; if (bus.instr_valid !== 1'b0 || bus.imem_rd !== 1'b0 || bus.pc_out !== '0) begin
      errors++; $display("FAIL arst_clear got valid=%b rd=%b pc=%h exp 0/0/0", bus.instr_valid, bus.imem_rd, bus.pc_out);
    end
    next_cycle();
    rst = 1'b1; bus.stall = 1'b0;
    sb_q = {14'd0, 14'd1};
    for (int c = 0; c < 4; c++) begin
      ev = (c >= 2);
      @(negedge clk);
      checks++; if (bus.instr_valid !== ev) begin errors++; $display("FAIL arst_restart_valid c=%0d got=%b exp=%b", c, bus.instr_valid, ev); end
      if (c == 0) begin
        checks++; if (bus.imem_rd !== 1'b1 || bus.imem_addr !== '0) begin
          errors++; $display("FAIL arst_restart_issue got rd=%b addr=%h exp rd=1 addr=0", bus.imem_rd, bus.imem_addr);
        end
      end
      if (bus.instr_valid === 1'b1 && bus.stall === 1'b0) begin
        checks++;
        if (sb_q.size() == 0) begin errors++; $display("FAIL arst_restart_sb c=%0d got pc=%h exp=<none>", c, bus.pc_out); end
        else begin
          exp_pc = sb_q.pop_front();
          if (bus.pc_out !== exp_pc || bus.instr !== mem_word(exp_pc)) begin
            errors++; $display("FAIL arst_restart_sb c=%0d got pc=%h instr=%h exp pc=%h instr=%h", c, bus.pc_out, bus.instr, exp_pc, mem_word(exp_pc));
          end
        end
      end
      next_cycle();
    end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL arst_left got=%0d exp=0", sb_q.size()); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_jump();
    test_jeq();
    test_jump_stall_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
